jt12_bus_master: RTL and testbench

- CPU-side bus initiator for jt12_top: takes register-write commands on a valid/ready stream and drives the chip's addr/din/cs_n/wr_n pins.
- Polls the status busy flag (dout[7]) before each write and optionally waits N output samples after a write.
- Sits between a stimulus or command player and the FM core, in benches and in SoC glue.

---
 rtl/jt12_bus_pkg.sv | 41 ++++
 rtl/jt12_bus_edge.sv | 43 ++++
 rtl/jt12_bus_master.sv | 218 +++++++++++++++++++++
 tb/tb_jt12_bus_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jt12_bus_pkg
//  Purpose : Shared types and constants for the jt12 CPU-side bus master.
//            State encoding, chip address constants, the latched command
//            record and a helper that forms the 2-bit chip address.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package jt12_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POLL = 3'd1,
        AWR  = 3'd2,
        AGAP = 3'd3,
        DWR  = 3'd4,
        DGAP = 3'd5,
        WAIT = 3'd6
    } state_t;

    localparam logic [1:0] ADDR_REG0 = 2'd0;
    localparam logic [1:0] ADDR_DAT0 = 2'd1;
    localparam logic [1:0] ADDR_REG1 = 2'd2;
    localparam logic [1:0] ADDR_DAT1 = 2'd3;

    typedef struct packed {
        logic        part;
        logic [7:0]  regnum;
        logic [7:0]  val;
        logic [15:0] wait_n;
    } cmd_t;

    // Chip address for a given bank and phase (0 = register, 1 = data).
    function automatic logic [1:0] bus_addr(input logic part, input logic data);
        if (part) return data ? ADDR_DAT1 : ADDR_REG1;
        else      return data ? ADDR_DAT0 : ADDR_REG0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_bus_edge.sv
`default_nettype none
// ============================================================================
//  Module  : jt12_bus_edge
//  Purpose : Rising-edge detector on the sample strobe plus a 16-bit edge
//            counter used while the master waits after a write.
//  Ports   : clk, rst         - clock, async active-high reset
//            snd_sample_i     - sample strobe from the FM core
//            count_en_i       - 1 = count edges, 0 = hold counter at zero
//            count_o          - number of rising edges seen while enabled
//  Rev     : 1.0  initial release
// ============================================================================
module jt12_bus_edge (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_sample_i,
    input  logic        count_en_i,
    output logic [15:0] count_o
);

    logic        sample_q;
    logic [15:0] count_q;
    logic        rise;

    // Edge detection runs every clk; it is deliberately not cen-gated.
    assign rise = snd_sample_i & ~sample_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            sample_q <= snd_sample_i;
            if (!count_en_i)
                count_q <= 16'd0;
            else if (rise && (count_q != 16'hFFFF))
                count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/jt12_bus_master.sv
`default_nettype none
// ============================================================================
//  Module  : jt12_bus_master
//  Purpose : CPU-side bus initiator for jt12_top. Accepts register-write
//            commands on a valid/ready stream, optionally polls the busy
//            flag, performs the address and data write phases and can wait
//            a number of sample strobes before completing.
//  Ports   : clk, rst, cen            - clock, async reset, clock enable
//            cmd_valid/cmd_ready      - command handshake
//            cmd_part/reg/val/wait    - command fields
//            snd_sample               - sample strobe from the core
//            addr/din/cs_n/wr_n       - chip write pins (registered)
//            dout                     - chip status, bit 7 = busy
//            done                     - one-clk completion pulse
//            timeout_err              - sticky busy-poll timeout flag
//  Rev     : 1.0  initial release
// ============================================================================
module jt12_bus_master
    import jt12_bus_pkg::*;
#(
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned GAP      = 1,
    parameter int unsigned USE_BUSY = 1,
    parameter int unsigned BUSY_TO  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_part,
    input  logic [7:0]  cmd_reg,
    input  logic [7:0]  cmd_val,
    input  logic [15:0] cmd_wait,
    input  logic        snd_sample,
    output logic [1:0]  addr,
    output logic [7:0]  din,
    output logic        cs_n,
    output logic        wr_n,
    input  logic [7:0]  dout,
    output logic        done,
    output logic        timeout_err
);

    localparam logic [7:0] PULSE_LAST = 8'(WR_PULSE - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
    localparam logic [7:0] BUSY_LAST  = 8'(BUSY_TO);

    state_t      state_q, state_d;
    logic [7:0]  tick_q,  tick_d;
    cmd_t        cmd_q,   cmd_d;
    logic [1:0]  addr_q,  addr_d;
    logic [7:0]  din_q,   din_d;
    logic        cs_n_q,  cs_n_d;
    logic        wr_n_q,  wr_n_d;
    logic        done_q,  done_d;
    logic        tout_q,  tout_d;
    logic [15:0] wait_cnt;
    logic        unused_dout;

    // Only the busy flag of the status byte matters here.
    assign unused_dout = ^dout[6:0];

    jt12_bus_edge u_edge (
        .clk          (clk),
        .rst          (rst),
        .snd_sample_i (snd_sample),
        .count_en_i   (state_q == WAIT),
        .count_o      (wait_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= 8'd0;
            cmd_q   <= '0;
            addr_q  <= 2'd0;
            din_q   <= 8'd0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state logic. Acceptance and the WAIT exit are clocked by clk
    // alone; every bus-timing phase advances only on cen ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cmd_d   = cmd_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.part   = cmd_part;
                    cmd_d.regnum = cmd_reg;
                    cmd_d.val    = cmd_val;
                    cmd_d.wait_n = cmd_wait;
                    state_d      = (USE_BUSY != 0) ? POLL : AWR;
                    tick_d       = 8'd0;
                end
            end
            POLL: begin
                if (cen) begin
                    if (!dout[7]) begin
                        state_d = AWR;
                        tick_d  = 8'd0;
                    end else if ((tick_q + 8'd1) == BUSY_LAST) begin
                        // Give up waiting and write anyway; flag it.
                        tout_d  = 1'b1;
                        state_d = AWR;
                        tick_d  = 8'd0;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            AWR: begin
                if (cen) begin
                    if (tick_q == PULSE_LAST) begin
                        state_d = AGAP;
                        tick_d  = 8'd0;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            AGAP: begin
                if (cen) begin
                    if (tick_q == GAP_LAST) begin
                        state_d = DWR;
                        tick_d  = 8'd0;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            DWR: begin
                if (cen) begin
                    if (tick_q == PULSE_LAST) begin
                        state_d = DGAP;
                        tick_d  = 8'd0;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            DGAP: begin
                if (cen) begin
                    if (tick_q == GAP_LAST) begin
                        state_d = (cmd_q.wait_n != 16'd0) ? WAIT : IDLE;
                        tick_d  = 8'd0;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == cmd_q.wait_n)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin values are a function of the state being entered, so the pins
    // change on the same edge as the state and stay put while cen is low.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        case (state_d)
            POLL: begin
                cs_n_d = 1'b0;
                addr_d = bus_addr(cmd_d.part, 1'b0);
            end
            AWR: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                addr_d = bus_addr(cmd_d.part, 1'b0);
                din_d  = cmd_d.regnum;
            end
            DWR: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                addr_d = bus_addr(cmd_d.part, 1'b1);
                din_d  = cmd_d.val;
            end
            default: begin
            end
        endcase
        done_d = (state_d == IDLE) && (state_q != IDLE);
    end

    assign cmd_ready   = (state_q == IDLE);
    assign addr        = addr_q;
    assign din         = din_q;
    assign cs_n        = cs_n_q;
    assign wr_n        = wr_n_q;
    assign done        = done_q;
    assign timeout_err = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_jt12_bus_master
//  Purpose : Self-checking bench for jt12_bus_master (default parameters).
//            A schedule-based reference model predicts the pins every cycle;
//            directed scenarios add hand-computed latency/width checks.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_jt12_bus_master;

    localparam int WR_PULSE = 2;
    localparam int GAP      = 1;
    localparam int BUSY_TO  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_part = 1'b0;
    logic [7:0]  cmd_reg = 8'd0;
    logic [7:0]  cmd_val = 8'd0;
    logic [15:0] cmd_wait = 16'd0;
    logic        snd_sample = 1'b0;
    logic [7:0]  dout = 8'd0;
    logic        cmd_ready, cs_n, wr_n, done, timeout_err;
    logic [1:0]  addr;
    logic [7:0]  din;

    int errors = 0;
    int checks = 0;

    jt12_bus_master #(.WR_PULSE(2), .GAP(1), .USE_BUSY(1), .BUSY_TO(255)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_val(cmd_val), .cmd_wait(cmd_wait),
        .snd_sample(snd_sample),
        .addr(addr), .din(din), .cs_n(cs_n), .wr_n(wr_n),
        .dout(dout), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Clock enable: one cycle in cen_div is enabled.
    int cen_div = 1;
    int cen_ph  = 0;
    always @(negedge clk) begin
        cen_ph = (cen_ph + 1 >= cen_div) ? 0 : cen_ph + 1;
        cen    = (cen_ph == 0);
    end

    // Sample strobe: one-clk pulse every 24 clk while enabled.
    logic snd_en  = 1'b0;
    int   snd_cnt = 0;
    always @(negedge clk) begin
        if (snd_en) begin
            snd_cnt++;
            snd_sample = ((snd_cnt % 24) == 0);
        end else begin
            snd_cnt    = 0;
            snd_sample = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a command is a schedule of segments
    // 0 busy poll, 1 address pulse, 2 gap, 3 data pulse, 4 gap, 5 wait.
    // ------------------------------------------------------------------
    logic        m_active, m_snd_prev, m_edge;
    int          m_seg, m_cnt, m_edges;
    logic        m_part;
    logic [7:0]  m_reg, m_val;
    logic [15:0] m_wait;
    logic        e_cs, e_wr, e_ready, e_done, e_to;
    logic [1:0]  e_addr;
    logic [7:0]  e_din;

    function automatic int seg_len(input int s);
        return (s == 1 || s == 3) ? WR_PULSE : GAP;
    endfunction

    task automatic m_enter(input int s);
        m_seg = s;
        m_cnt = 0;
        e_cs  = 1'b1;
        e_wr  = 1'b1;
        if (s == 0) begin
            e_cs = 1'b0; e_addr = {m_part, 1'b0};
        end else if (s == 1) begin
            e_cs = 1'b0; e_wr = 1'b0; e_addr = {m_part, 1'b0}; e_din = m_reg;
        end else if (s == 3) begin
            e_cs = 1'b0; e_wr = 1'b0; e_addr = {m_part, 1'b1}; e_din = m_val;
        end else if (s == 5) begin
            m_edges = 0;
        end
    endtask

    task automatic m_finish();
        m_active = 1'b0;
        e_done   = 1'b1;
        e_cs     = 1'b1;
        e_wr     = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_snd_prev = 1'b0; m_seg = 0; m_cnt = 0; m_edges = 0;
            e_cs = 1'b1; e_wr = 1'b1; e_addr = 2'd0; e_din = 8'd0;
            e_ready = 1'b1; e_done = 1'b0; e_to = 1'b0;
        end else begin
            m_edge = snd_sample && !m_snd_prev;
            e_done = 1'b0;
            if (!m_active) begin
                if (cmd_valid) begin
                    m_part = cmd_part; m_reg = cmd_reg; m_val = cmd_val; m_wait = cmd_wait;
                    m_active = 1'b1;
                    m_enter(0);
                end
            end else if (m_seg == 0) begin
                if (cen) begin
                    if (!dout[7]) m_enter(1);
                    else begin
                        m_cnt++;
                        if (m_cnt == BUSY_TO) begin e_to = 1'b1; m_enter(1); end
                    end
                end
            end else if (m_seg <= 4) begin
                if (cen) begin
                    m_cnt++;
                    if (m_cnt == seg_len(m_seg)) begin
                        if (m_seg < 4)            m_enter(m_seg + 1);
                        else if (m_wait != 16'd0) m_enter(5);
                        else                      m_finish();
                    end
                end
            end else begin
                if (m_edges == int'(m_wait)) m_finish();
                else if (m_edge)             m_edges++;
            end
            e_ready    = !m_active;
            m_snd_prev = snd_sample;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            checks++;
            if ({cs_n, wr_n, addr, din, cmd_ready, done, timeout_err} !==
                {e_cs, e_wr, e_addr, e_din, e_ready, e_done, e_to}) begin
                errors++;
                $display("FAIL pins t=%0t got cs_n=%b wr_n=%b addr=%0d din=%h rdy=%b done=%b to=%b want cs_n=%b wr_n=%b addr=%0d din=%h rdy=%b done=%b to=%b",
                         $time, cs_n, wr_n, addr, din, cmd_ready, done, timeout_err,
                         e_cs, e_wr, e_addr, e_din, e_ready, e_done, e_to);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send(input logic p, input logic [7:0] r, input logic [7:0] v,
                        input logic [15:0] w, input bit keep);
        @(negedge clk);
        cmd_part = p; cmd_reg = r; cmd_val = v; cmd_wait = w; cmd_valid = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #2;
        if (!keep) cmd_valid = 1'b0;
    endtask

    int         r_lat, r_first_low, r_low_run, r_to_lat;
    logic [1:0] r_addr_first, r_addr_last;
    logic [7:0] r_din_first, r_din_last;

    // Runs until done; busy_ticks > 0 releases dout[7] after that many clks.
    task automatic run_to_done(input int maxc, input int busy_ticks);
        bit first_over = 0;
        r_first_low = -1; r_low_run = 0; r_to_lat = -1; r_lat = -1;
        for (int lat = 1; lat <= maxc; lat++) begin
            @(posedge clk);
            #2;
            if (!wr_n) begin
                if (r_first_low < 0) begin
                    r_first_low = lat; r_addr_first = addr; r_din_first = din;
                end
                if (!first_over) r_low_run++;
                r_addr_last = addr; r_din_last = din;
            end else if (r_first_low >= 0) begin
                first_over = 1;
            end
            if (timeout_err && r_to_lat < 0) r_to_lat = lat;
            if (busy_ticks > 0 && lat == busy_ticks) dout = 8'h00;
            if (done) begin
                r_lat = lat;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_wait: got no done within %0d clk want done", maxc);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Basic write, busy never set.
        send(1'b0, 8'h28, 8'hF0, 16'd0, 0);
        run_to_done(50, 0);
        chk("t1_latency", r_lat, 7);
        chk("t1_first_low", r_first_low, 1);
        chk("t1_low_width", r_low_run, 2);
        chk("t1_addr_reg", r_addr_first, 0);
        chk("t1_din_reg", r_din_first, 8'h28);
        chk("t1_addr_dat", r_addr_last, 1);
        chk("t1_din_dat", r_din_last, 8'hF0);

        // Busy for 10 ticks, then free.
        dout = 8'h80;
        send(1'b0, 8'h2B, 8'h80, 16'd0, 0);
        run_to_done(100, 10);
        chk("t2_poll_len", r_first_low, 11);
        chk("t2_latency", r_lat, 17);
        chk("t2_no_timeout", timeout_err, 0);

        // Busy stuck: timeout, write still happens on bank 1.
        dout = 8'h80;
        send(1'b1, 8'hB4, 8'hC0, 16'd0, 0);
        run_to_done(400, 0);
        dout = 8'h00;
        chk("t3_timeout_at", r_to_lat, 255);
        chk("t3_first_low", r_first_low, 255);
        chk("t3_latency", r_lat, 261);
        chk("t3_addr_reg", r_addr_first, 2);
        chk("t3_addr_dat", r_addr_last, 3);
        chk("t3_din_dat", r_din_last, 8'hC0);
        chk("t3_sticky", timeout_err, 1);

        // Wait for three sample edges after the write.
        send(1'b0, 8'h40, 8'h1F, 16'd3, 0);
        snd_en = 1'b1;
        run_to_done(200, 0);
        snd_en = 1'b0;
        chk("t4_latency", r_lat, 73);

        // Slow cen and back-to-back commands; fields change after accept.
        cen_div = 6;
        send(1'b0, 8'h30, 8'h55, 16'd0, 1);
        cmd_part = 1'b1; cmd_reg = 8'hA4; cmd_val = 8'h22; cmd_wait = 16'd0;
        run_to_done(200, 0);
        chk("t5_low_width", r_low_run, 12);
        chk("t5_din_dat_a", r_din_last, 8'h55);
        chk("t5_ready_at_done", cmd_ready, 1);
        @(posedge clk);
        #2;
        chk("t5_next_accepted", cmd_ready, 0);
        cmd_valid = 1'b0;
        run_to_done(200, 0);
        chk("t5_addr_reg_b", r_addr_first, 2);
        chk("t5_addr_dat_b", r_addr_last, 3);
        chk("t5_din_dat_b", r_din_last, 8'h22);
        cen_div = 1;
        repeat (2) @(negedge clk);

        // Reset in the middle of the data pulse.
        send(1'b0, 8'h30, 8'h71, 16'd0, 0);
        repeat (4) @(posedge clk);
        #2;
        chk("t6_in_dwr_wr_n", wr_n, 0);
        chk("t6_in_dwr_addr", addr, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_cs_n", cs_n, 1);
        chk("t6_rst_wr_n", wr_n, 1);
        chk("t6_rst_ready", cmd_ready, 1);
        chk("t6_rst_timeout", timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 8'h22, 8'h08, 16'd0, 0);
        run_to_done(50, 0);
        chk("t6_latency", r_lat, 7);
        chk("t6_addr_dat", r_addr_last, 3);
        chk("t6_din_dat", r_din_last, 8'h08);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
